// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receive sequencer with oversample prescaler and valid/ready holding register.
// Define UART_RX_PARITY_EN to insert a parity bit between data and stop.
module uart_rx_ctrl #(
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = 16,
    parameter int Tp         = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    input  logic                 rx_sync_i,
    output logic                 sample_en_o,
    output logic                 sample_rst_o,
    output logic [7:0]           data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    input  logic                 clr_i,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd_i,
    output logic                 parity_err_o,
`endif
    output logic                 busy_o
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0 || Tp < 0) begin : g_bad_param
        $error("uart_rx_ctrl: OVERSAMPLE must be a power of two >= 4 and Tp non-negative");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam state_t AFTER_DATA = PARITY;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t               state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [2:0]           idx, idx_d;
    logic [7:0]           sr;
    logic                 shift, done, ferr, accept;
    logic [DIV_WIDTH-1:0] pre_cnt, term_q, term;
    logic                 wrap;
    logic                 par_bad, par_bad_d;

    // The divisor is sampled on the first count of each period, so a change lands at the next wrap.
    assign term = (pre_cnt == '0) ? ((divisor_i == '0) ? '0 : divisor_i - 1'b1) : term_q;
    assign wrap = pre_cnt == term;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_cnt      <= '0;
            term_q       <= '0;
            sample_en_o  <= 1'b0;
            sample_rst_o <= 1'b1;
        end else begin
            sample_rst_o <= ~enable_i;
            sample_en_o  <= enable_i & wrap;
            term_q       <= term;
            pre_cnt      <= (!enable_i || wrap) ? '0 : pre_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        idx_d     = idx;
        par_bad_d = par_bad;
        shift     = 1'b0;
        done      = 1'b0;
        ferr      = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (sample_en_o) begin
            cnt_d = cnt + 1'b1;
            case (state)
                IDLE: if (!rx_sync_i) begin
                    state_d = START;
                    cnt_d   = '0;
                end
                START: if (cnt == MID) begin
                    state_d = rx_sync_i ? IDLE : DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                DATA: if (cnt == LAST) begin
                    shift   = 1'b1;
                    idx_d   = idx + 1'b1;
                    state_d = (idx == 3'd7) ? AFTER_DATA : DATA;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (cnt == LAST) begin
                    state_d   = STOP;
                    par_bad_d = (^sr ^ rx_sync_i) != parity_odd_i;
                end
`endif
                STOP: if (cnt == LAST) begin
                    state_d = IDLE;
                    done    = rx_sync_i;
                    ferr    = ~rx_sync_i;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sr      <= '0;
            par_bad <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            idx     <= idx_d;
            par_bad <= par_bad_d;
            if (shift) sr <= {rx_sync_i, sr[7:1]};
        end
    end

    // A completing byte may replace the held one only when the consumer takes it that same cycle.
    assign accept = done & (~valid_o | ready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            overrun_o    <= 1'b0;
            frame_err_o  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
        end else begin
            frame_err_o <= ferr;
            overrun_o   <= (done & ~accept) | (overrun_o & ~clr_i);
`ifdef UART_RX_PARITY_EN
            parity_err_o <= done & par_bad;
`endif
            if (accept) begin
                data_o  <= sr;
                valid_o <= 1'b1;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    assign busy_o = state != IDLE;
endmodule
